// File: rtl/scan_pkg.sv
// scan_pkg - shared definitions for the minterm scan controller.
//   state_t           : controller state encoding (IDLE/SCAN/FLUSH/DONE)
//   N_MINTERMS        : number of input combinations swept (4 inputs -> 16)
//   DEFAULT_EXP_TABLE : default expected truth table (bit m = f(m))
//   lowest_set()      : index of the lowest set bit, 0 when the vector is 0
package scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int          N_MINTERMS        = 16;
  localparam logic [15:0] DEFAULT_EXP_TABLE = 16'h6EEE;

  // Scans from the top so the last hit wins, leaving the lowest index.
  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = N_MINTERMS - 1; i >= 0; i--) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/scan_delay_line.sv
// scan_delay_line - LAT-stage shift register carrying the capture index and
// its valid flag, so that the index leaving the line lines up with the
// function unit's registered response to that same minterm.
// Ports:
//   clk       : clock, rising edge
//   clear     : asynchronous active-high reset, empties the line
//   in_valid  : a minterm is being driven this cycle
//   in_idx    : minterm being driven
//   out_valid : out_idx is the minterm whose response is on f_q now
//   out_idx   : capture index, LAT edges behind in_idx
module scan_delay_line #(
  parameter int LAT = 1,
  parameter int W   = 4
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         in_valid,
  input  logic [W-1:0] in_idx,
  output logic         out_valid,
  output logic [W-1:0] out_idx
);

  // Element 0 is the line input; element gi+1 is the output of stage gi.
  logic         valid_chain [LAT+1];
  logic [W-1:0] idx_chain   [LAT+1];

  assign valid_chain[0] = in_valid;
  assign idx_chain[0]   = in_idx;

  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_stage
      always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
          valid_chain[gi+1] <= 1'b0;
          idx_chain[gi+1]   <= '0;
        end else begin
          valid_chain[gi+1] <= valid_chain[gi];
          idx_chain[gi+1]   <= idx_chain[gi];
        end
      end
    end
  endgenerate

  assign out_valid = valid_chain[LAT];
  assign out_idx   = idx_chain[LAT];

endmodule

// File: rtl/minterm_scan_ctrl.sv
// minterm_scan_ctrl - sweeps minterms 0..15 through an external registered
// 4-input function unit and assembles its responses into a truth table.
// Optional compare against EXP_TABLE is compiled in with SCAN_COMPARE_EN.
// Parameters:
//   LAT       : register latency of the function unit, 1..4
//   EXP_TABLE : expected table (bit m = f(m)), used only with compare
// Ports:
//   clk        : clock, rising edge
//   clear      : asynchronous active-high reset
//   start      : sweep request, sampled only in IDLE
//   f_q        : registered output of the function unit
//   a,b,c,d    : function unit inputs, {a,b,c,d} = m_idx
//   m_idx      : minterm currently driven
//   busy       : high during SCAN and FLUSH
//   done       : one-cycle pulse when table_q is complete
//   table_q    : captured truth table
//   mismatch   : (SCAN_COMPARE_EN) table_q differs from EXP_TABLE
//   first_fail : (SCAN_COMPARE_EN) lowest differing minterm, 0 if none
module minterm_scan_ctrl
  import scan_pkg::*;
#(
  parameter int          LAT       = 1,
  parameter logic [15:0] EXP_TABLE = DEFAULT_EXP_TABLE
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        start,
  input  logic        f_q,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic [3:0]  m_idx,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_q
`ifdef SCAN_COMPARE_EN
  ,
  output logic        mismatch,
  output logic [3:0]  first_fail
`endif
);

  localparam logic [1:0] FLUSH_LAST = 2'(LAT - 1);

  state_t      state;
  logic [1:0]  flush_cnt;
  logic        cap_valid;
  logic [3:0]  cap_idx;
  logic [15:0] table_next;

  assign {a, b, c, d} = m_idx;

  // Only SCAN cycles enter the line; FLUSH pushes bubbles while the last
  // LAT minterms drain out.
  scan_delay_line #(
    .LAT (LAT),
    .W   (4)
  ) u_delay (
    .clk       (clk),
    .clear     (clear),
    .in_valid  (state == ST_SCAN),
    .in_idx    (m_idx),
    .out_valid (cap_valid),
    .out_idx   (cap_idx)
  );

  // Table including this cycle's capture; also the value compared at the
  // FLUSH->DONE edge so the final bit is part of the check.
  always_comb begin
    table_next = table_q;
    if ((state == ST_SCAN || state == ST_FLUSH) && cap_valid) begin
      table_next[cap_idx] = f_q;
    end
  end

`ifndef SCAN_COMPARE_EN
  // EXP_TABLE has no consumer without the compare logic.
  logic unused_exp_table;
  assign unused_exp_table = ^EXP_TABLE;
`endif

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state      <= ST_IDLE;
      m_idx      <= 4'd0;
      flush_cnt  <= 2'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      table_q    <= 16'h0000;
`ifdef SCAN_COMPARE_EN
      mismatch   <= 1'b0;
      first_fail <= 4'd0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_SCAN;
            m_idx      <= 4'd0;
            flush_cnt  <= 2'd0;
            busy       <= 1'b1;
            table_q    <= 16'h0000;
`ifdef SCAN_COMPARE_EN
            mismatch   <= 1'b0;
            first_fail <= 4'd0;
`endif
          end
        end
        ST_SCAN: begin
          table_q <= table_next;
          // Terminal compare rather than wrap so m_idx parks at 15.
          if (m_idx == 4'd15) begin
            state     <= ST_FLUSH;
            flush_cnt <= 2'd0;
          end else begin
            m_idx <= m_idx + 4'd1;
          end
        end
        ST_FLUSH: begin
          table_q <= table_next;
          if (flush_cnt == FLUSH_LAST) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
`ifdef SCAN_COMPARE_EN
            mismatch   <= (table_next != EXP_TABLE);
            first_fail <= lowest_set(table_next ^ EXP_TABLE);
`endif
          end else begin
            flush_cnt <= flush_cnt + 2'd1;
          end
        end
        default: begin // ST_DONE
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_minterm_scan_ctrl.sv
// tb_minterm_scan_ctrl - two controller instances (LAT=1 and LAT=3), each
// driving a behavioural registered function unit of matching latency.
// Expected tables are queued when a sweep is started and compared when done
// pulses. Compare outputs are checked when SCAN_COMPARE_EN is defined.
module tb_minterm_scan_ctrl;
  import scan_pkg::*;

  typedef struct {
    logic [15:0] tbl;
    logic        mm;
    logic [3:0]  ff;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             clear;
  logic [1:0]       start;
  logic [1:0]       f_q;
  logic [1:0]       a, b, c, d;
  logic [1:0][3:0]  m_idx;
  logic [1:0]       busy, done;
  logic [1:0][15:0] table_q;
`ifdef SCAN_COMPARE_EN
  logic [1:0]       mismatch;
  logic [1:0][3:0]  first_fail;
`endif

  int n_checks = 0;
  int n_fails  = 0;
  int fsel     = 0;

  exp_t q0[$];
  exp_t q1[$];
  int   done_cnt[2];
  int   done_cyc[2];

  minterm_scan_ctrl #(.LAT(1)) dut1 (
    .clk(clk), .clear(clear), .start(start[0]), .f_q(f_q[0]),
    .a(a[0]), .b(b[0]), .c(c[0]), .d(d[0]), .m_idx(m_idx[0]),
    .busy(busy[0]), .done(done[0]), .table_q(table_q[0])
`ifdef SCAN_COMPARE_EN
    , .mismatch(mismatch[0]), .first_fail(first_fail[0])
`endif
  );

  minterm_scan_ctrl #(.LAT(3)) dut3 (
    .clk(clk), .clear(clear), .start(start[1]), .f_q(f_q[1]),
    .a(a[1]), .b(b[1]), .c(c[1]), .d(d[1]), .m_idx(m_idx[1]),
    .busy(busy[1]), .done(done[1]), .table_q(table_q[1])
`ifdef SCAN_COMPARE_EN
    , .mismatch(mismatch[1]), .first_fail(first_fail[1])
`endif
  );

  // Function under test: sel 0 = c^d | ~a&d | ~b&d, sel 1 = constant 1.
  function automatic logic fmodel(input logic [3:0] m, input int sel);
    logic av, bv, cv, dv;
    {av, bv, cv, dv} = m;
    if (sel == 1) return 1'b1;
    return (cv ^ dv) | (~av & dv) | (~bv & dv);
  endfunction

  function automatic exp_t model(input int sel);
    exp_t        e;
    logic [15:0] x;
    for (int m = 0; m < 16; m++) e.tbl[m] = fmodel(4'(m), sel);
    e.mm = (e.tbl != 16'h6EEE);
    e.ff = 4'd0;
    x = e.tbl ^ 16'h6EEE;
    for (int m = 0; m < 16; m++) begin
      if (x[m]) begin
        e.ff = 4'(m);
        break;
      end
    end
    return e;
  endfunction

  // Registered function units: 1 stage and 3 stages.
  logic       unit1;
  logic [2:0] unit3;
  always @(posedge clk) unit1 <= fmodel({a[0], b[0], c[0], d[0]}, fsel);
  always @(posedge clk) unit3 <= {unit3[1:0], fmodel({a[1], b[1], c[1], d[1]}, fsel)};
  assign f_q[0] = unit1;
  assign f_q[1] = unit3[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: pop and compare whenever done pulses.
  always @(negedge clk) begin
    if (done[0]) begin
      exp_t e;
      done_cnt[0]++;
      done_cyc[0] = cyc;
      check_eq("busy_with_done1", 32'(busy[0]), 32'd0);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check_eq("table1", 32'(table_q[0]), 32'(e.tbl));
`ifdef SCAN_COMPARE_EN
        check_eq("mismatch1", 32'(mismatch[0]), 32'(e.mm));
        check_eq("first_fail1", 32'(first_fail[0]), 32'(e.ff));
`endif
        $display("sweep lat1: table=%h at cycle %0d", table_q[0], cyc);
      end else begin
        check_eq("unexpected_done1", 32'(done[0]), 32'd0);
      end
    end
    if (done[1]) begin
      exp_t e;
      done_cnt[1]++;
      done_cyc[1] = cyc;
      check_eq("busy_with_done3", 32'(busy[1]), 32'd0);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check_eq("table3", 32'(table_q[1]), 32'(e.tbl));
`ifdef SCAN_COMPARE_EN
        check_eq("mismatch3", 32'(mismatch[1]), 32'(e.mm));
        check_eq("first_fail3", 32'(first_fail[1]), 32'(e.ff));
`endif
        $display("sweep lat3: table=%h at cycle %0d", table_q[1], cyc);
      end else begin
        check_eq("unexpected_done3", 32'(done[1]), 32'd0);
      end
    end
  end

  // Settle point well after the monitor's negedge sampling.
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic push_exp(input int s, input int sel);
    if (s == 0) q0.push_back(model(sel));
    else        q1.push_back(model(sel));
  endtask

  // Pulses start for one cycle; start_c is the cycle count of the start edge.
  task automatic do_start(input int s, input bit push, output int start_c);
    if (push) push_exp(s, fsel);
    start[s] = 1'b1;
    tick();
    start[s] = 1'b0;
    start_c = cyc;
  endtask

  task automatic wait_done(input int s, input int start_c, input int lat,
                           input bit chk_busy, input string tag);
    int prev, nbusy, nlast, n;
    prev = done_cnt[s]; nbusy = 0; nlast = 0; n = 0;
    while (done_cnt[s] == prev && n < 200) begin
      if (busy[s]) nbusy++;
      if (busy[s] && m_idx[s] == 4'd15) nlast++;
      tick();
      n++;
    end
    check_eq({tag, "_done_seen"}, 32'(done_cnt[s] - prev), 32'd1);
    check_eq({tag, "_latency"}, 32'(done_cyc[s] - start_c), 32'(16 + lat));
    if (chk_busy) begin
      check_eq({tag, "_busy_cycles"}, 32'(nbusy), 32'(16 + lat));
      check_eq({tag, "_flush_span"}, 32'(nlast), 32'(1 + lat));
    end
    tick(); // DONE -> IDLE
  endtask

  initial begin
    int sc, n, prev;
    int dc[$];
    clear = 1'b1;
    start = 2'b00;
    done_cnt[0] = 0; done_cnt[1] = 0;
    done_cyc[0] = 0; done_cyc[1] = 0;
    repeat (3) tick();

    // Reset state
    check_eq("rst_m_idx", 32'(m_idx[0]), 32'd0);
    check_eq("rst_abcd", 32'({a[0], b[0], c[0], d[0]}), 32'd0);
    check_eq("rst_busy", 32'(busy[0]), 32'd0);
    check_eq("rst_done", 32'(done[0]), 32'd0);
    check_eq("rst_table", 32'(table_q[0]), 32'd0);
    check_eq("rst_table3", 32'(table_q[1]), 32'd0);
`ifdef SCAN_COMPARE_EN
    check_eq("rst_mismatch", 32'(mismatch[0]), 32'd0);
    check_eq("rst_first_fail", 32'(first_fail[0]), 32'd0);
`endif
    clear = 1'b0;
    tick();

    // Nominal sweep, LAT=1
    fsel = 0;
    do_start(0, 1'b1, sc);
    wait_done(0, sc, 1, 1'b1, "lat1_sop");
    check_eq("hold_table", 32'(table_q[0]), 32'h6EEE);

    // Constant-1 unit
    fsel = 1;
    do_start(0, 1'b1, sc);
    wait_done(0, sc, 1, 1'b1, "lat1_one");
    fsel = 0;

    // LAT=3
    do_start(1, 1'b1, sc);
    wait_done(1, sc, 3, 1'b1, "lat3_sop");

    // clear at m_idx == 7
    prev = done_cnt[0];
    do_start(0, 1'b1, sc);
    n = 0;
    while (m_idx[0] != 4'd7 && n < 50) begin
      tick();
      n++;
    end
    check_eq("reach_m7", 32'(m_idx[0]), 32'd7);
    clear = 1'b1;
    #1;
    check_eq("clr_m_idx", 32'(m_idx[0]), 32'd0);
    check_eq("clr_busy", 32'(busy[0]), 32'd0);
    check_eq("clr_table", 32'(table_q[0]), 32'd0);
    check_eq("clr_abcd", 32'({a[0], b[0], c[0], d[0]}), 32'd0);
    void'(q0.pop_back());
    tick();
    clear = 1'b0;
    repeat (25) tick();
    check_eq("clr_no_done", 32'(done_cnt[0] - prev), 32'd0);
    do_start(0, 1'b1, sc);
    wait_done(0, sc, 1, 1'b1, "after_clr");

    // Extra start during SCAN is ignored
    prev = done_cnt[0];
    do_start(0, 1'b1, sc);
    repeat (5) tick();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    wait_done(0, sc, 1, 1'b0, "restart_ign");
    repeat (30) tick();
    check_eq("restart_one_done", 32'(done_cnt[0] - prev), 32'd1);

    // start held high: back-to-back sweeps
    prev = done_cnt[0];
    for (int i = 0; i < 3; i++) push_exp(0, 0);
    start[0] = 1'b1;
    n = 0;
    while (done_cnt[0] < prev + 3 && n < 120) begin
      tick();
      n++;
      if (done_cnt[0] > prev + dc.size()) begin
        dc.push_back(done_cyc[0]);
        if (dc.size() == 3) start[0] = 1'b0;
      end
    end
    start[0] = 1'b0;
    check_eq("held_dones", 32'(dc.size()), 32'd3);
    if (dc.size() == 3) begin
      check_eq("held_gap1", 32'(dc[1] - dc[0]), 32'd19);
      check_eq("held_gap2", 32'(dc[2] - dc[1]), 32'd19);
    end
    repeat (25) tick();
    check_eq("held_no_extra", 32'(done_cnt[0] - prev), 32'd3);
    check_eq("sb_drained1", 32'(q0.size()), 32'd0);
    check_eq("sb_drained3", 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
